// File: rtl/check_divisibility_seq_if.sv
// Valid/ready job stream for the sequential divisibility checker.
// The producer/consumer side uses master; the checker uses slave.
interface check_divisibility_seq_if #(
    parameter int WIDTH = 16,
    parameter int DW    = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] number;
    logic [DW-1:0]    divisor;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    remainder;
    logic             divisible;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, number, divisor, out_ready,
        input  in_ready, out_valid, remainder, divisible, err, busy
    );

    modport slave (
        input  in_valid, number, divisor, out_ready,
        output in_ready, out_valid, remainder, divisible, err, busy
    );
endinterface

// File: rtl/check_divisibility_seq.sv
// Bit-serial remainder engine: number mod D, one dividend bit per clock, MSB first,
// using r <= (2r + bit) mod D. One job in flight at a time.
module check_divisibility_seq #(
    parameter int WIDTH = 16,
    parameter int DW    = 8
) (
    input logic                    clk,
    input logic                    rst,
    check_divisibility_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    d_q;
    logic [DW-1:0]    r;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    rem_q;
    logic             div_q;
    logic             err_q;

    logic [DW:0]      t;
    logic [DW:0]      diff;
    logic [DW-1:0]    r_next;
    logic             accept;
    logic             last_bit;

    // One step of the serial reduction; r < D keeps t < 2D so DW+1 bits suffice.
    always_comb begin
        t      = {r, shreg[WIDTH-1]};
        diff   = t - {1'b0, d_q};
        r_next = (t >= {1'b0, d_q}) ? diff[DW-1:0] : t[DW-1:0];
    end

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_bit = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_next = (bus.divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            d_q   <= '0;
            r     <= '0;
            cnt   <= '0;
            rem_q <= '0;
            div_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                shreg <= bus.number;
                d_q   <= bus.divisor;
                r     <= '0;
                cnt   <= CW'(WIDTH);
                // Divide-by-zero skips RUN and reports straight away.
                if (bus.divisor == '0) begin
                    rem_q <= '0;
                    div_q <= 1'b0;
                    err_q <= 1'b1;
                end
            end else if (state == RUN) begin
                r     <= r_next;
                shreg <= shreg << 1;
                cnt   <= cnt - CW'(1);
                if (last_bit) begin
                    rem_q <= r_next;
                    div_q <= (r_next == '0);
                    err_q <= 1'b0;
                end
            end
        end
    end

    assign bus.remainder = rem_q;
    assign bus.divisible = div_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_check_divisibility_seq.sv
// Directed bench: stimulus pushes expected results; a negedge monitor pops on each output handshake.
module tb_check_divisibility_seq;
    localparam int WIDTH = 16;
    localparam int DW    = 8;

    typedef struct {
        logic [DW-1:0] rem;
        logic          div;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    check_divisibility_seq_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    check_divisibility_seq #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got remainder %0d with no job pending", bus.remainder);
            end else begin
                e = sb.pop_front();
                chk("remainder", 32'(bus.remainder), 32'(e.rem));
                chk("divisible", 32'(bus.divisible), 32'(e.div));
                chk("err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic start_job(input logic [WIDTH-1:0] n, input logic [DW-1:0] d, input bit push,
                             input logic [DW-1:0] er, input logic ed, input logic ee);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.number   = n;
        bus.divisor  = d;
        if (push) sb.push_back('{er, ed, ee});
        @(posedge clk);
        #1;
        // Garbage on the inputs mid-job must not disturb the result.
        bus.in_valid = 1'b0;
        bus.number   = WIDTH'($urandom);
        bus.divisor  = DW'($urandom);
    endtask

    task automatic wait_result(input logic [DW-1:0] d);
        int lat = 0;
        while (!bus.out_valid && lat < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (d == '0) chk("latency_dz", 32'(lat <= 1), 32'd1);
        else         chk("latency", 32'(lat), 32'(WIDTH));
    endtask

    task automatic drain();
        int w = 0;
        while (bus.out_valid && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic job(input logic [WIDTH-1:0] n, input logic [DW-1:0] d,
                       input logic [DW-1:0] er, input logic ed, input logic ee);
        start_job(n, d, 1'b1, er, ed, ee);
        wait_result(d);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.number    = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_divisible", 32'(bus.divisible), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        job(16'hFFFF, 8'd3,   8'd0, 1'b1, 1'b0);
        job(16'd1000, 8'd7,   8'd6, 1'b0, 1'b0);
        job(16'd12345, 8'd10, 8'd5, 1'b0, 1'b0);
        job(16'd65535, 8'd255, 8'd0, 1'b1, 1'b0);
        job(16'd5, 8'd200,    8'd5, 1'b0, 1'b0);
        job(16'd42, 8'd0,     8'd0, 1'b0, 1'b1);
        job(16'd42, 8'd1,     8'd0, 1'b1, 1'b0);
        job(16'd0, 8'd13,     8'd0, 1'b1, 1'b0);
        job(16'd65535, 8'd254, 8'd3, 1'b0, 1'b0);
        job(16'd100, 8'd7,    8'd2, 1'b0, 1'b0);

        // Back-pressure: result held stable while the consumer stalls.
        bus.out_ready = 1'b0;
        start_job(16'd1000, 8'd7, 1'b1, 8'd6, 1'b0, 1'b0);
        wait_result(8'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_remainder", 32'(bus.remainder), 32'd6);
            chk("hold_divisible", 32'(bus.divisible), 32'd0);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-job aborts without producing a result.
        start_job(16'd1000, 8'd7, 1'b0, 8'd0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("run_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        repeat (WIDTH + 8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        job(16'd1000, 8'd7, 8'd6, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
